// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/fa_fs_cell.sv
// One-bit full subtractor / full adder cell; mode selects borrow or carry chain.
module fa_fs_cell
    import arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic q,
    input  logic mode,
    output logic s,
    output logic qn
);

    logic axb;

    assign axb = a ^ b;
    assign s   = axb ^ q;

    // Borrow propagates on equal bits, carry propagates on differing bits.
    always_comb begin
        qn = 1'b0;
        if (mode == MODE_ADD) begin
            qn = (a & b) | (axb & q);
        end else begin
            qn = (~a & b) | (~axb & q);
        end
    end

endmodule

// File: rtl/serial_addsub_n.sv
// Bit-serial WIDTH-bit subtractor/adder: one bit per clock, LSB first, single shared cell.
module serial_addsub_n
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned   CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             q;
    logic             mode_r;
    logic             s;
    logic             qn;

    fa_fs_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .q    (q),
        .mode (mode_r),
        .s    (s),
        .qn   (qn)
    );

    // FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            q      <= 1'b0;
            mode_r <= MODE_SUB;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            co     <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        r_sr   <= '0;
                        q      <= ci;
                        mode_r <= mode;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= {s, r_sr[WIDTH-1:1]};
                    q    <= qn;
                    cnt  <= cnt + CW'(1);
                    // MSB step: q is the chain value into the MSB, qn the value out of it.
                    if (cnt == LAST) begin
                        result <= {s, r_sr[WIDTH-1:1]};
                        co     <= qn;
                        ovf    <= q ^ qn;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
